// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    IFU_IDLE  = 2'd0,
    IFU_REQ   = 2'd1,
    IFU_FAULT = 2'd2
  } ifu_state_t;

  localparam int unsigned IFU_INST_BYTES = 4;
  localparam int unsigned IFU_INST_BITS  = IFU_INST_BYTES * 8;
  localparam int unsigned IFU_ALIGN_W    = $clog2(IFU_INST_BYTES);

endpackage

// File: rtl/ifu_line.sv
// Single prefetch line: tag/data/valid storage, tag compare and slot select.
module ifu_line
  import ifu_pkg::*;
#(
  parameter int unsigned WORD_LEN = 64,
  parameter int unsigned TAG_W    = 29,
  parameter int unsigned SLOT_W   = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     fill_en_i,
  input  logic                     inval_en_i,
  input  logic [TAG_W-1:0]         fill_tag_i,
  input  logic [WORD_LEN-1:0]      fill_data_i,
  input  logic [TAG_W-1:0]         pc_tag_i,
  input  logic [SLOT_W-1:0]        pc_slot_i,
  output logic                     tag_match_c,
  output logic [IFU_INST_BITS-1:0] slot_data_c
);

  localparam int unsigned SLOTS = WORD_LEN / IFU_INST_BITS;

  logic                                  line_valid_q, line_valid_d;
  logic [TAG_W-1:0]                      line_tag_q, line_tag_d;
  logic [WORD_LEN-1:0]                   line_data_q, line_data_d;
  logic [SLOTS-1:0][IFU_INST_BITS-1:0]   slots_c;

  // Next line contents: fill overwrites, invalidate only clears valid.
  always_comb begin
    line_valid_d = line_valid_q;
    line_tag_d   = line_tag_q;
    line_data_d  = line_data_q;
    if (fill_en_i) begin
      line_valid_d = 1'b1;
      line_tag_d   = fill_tag_i;
      line_data_d  = fill_data_i;
    end else if (inval_en_i) begin
      line_valid_d = 1'b0;
    end
  end

  // Line storage with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      line_valid_q <= 1'b0;
      line_tag_q   <= '0;
      line_data_q  <= '0;
    end else begin
      line_valid_q <= line_valid_d;
      line_tag_q   <= line_tag_d;
      line_data_q  <= line_data_d;
    end
  end

  // Little-endian slot view of the line; slot k sits at bits [32k+31:32k].
  assign slots_c     = line_data_q;
  assign slot_data_c = slots_c[pc_slot_i];
  assign tag_match_c = line_valid_q && (line_tag_q == pc_tag_i);

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one-line prefetch buffer refilled over a req/ack port.
module ifu
  import ifu_pkg::*;
#(
  parameter int unsigned WORD_LEN = 64,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [31:0]         pc_i,
  output logic                inst_valid_o,
  output logic [31:0]         inst_o,
  output logic                fault_o,
  output logic                mem_req_o,
  output logic [31:0]         mem_addr_o,
  input  logic                mem_ack_i,
  input  logic [WORD_LEN-1:0] mem_data_i,
  input  logic                mem_err_i
);

  localparam int unsigned LINE_BYTES = WORD_LEN / 8;
  localparam int unsigned OFS        = $clog2(LINE_BYTES);
  localparam int unsigned TAG_W      = 32 - OFS;
  localparam int unsigned SLOTS      = WORD_LEN / IFU_INST_BITS;
  localparam int unsigned SLOT_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned CNT_W      = $clog2(TIMEOUT + 1);

  ifu_state_t         state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic               fault_q, fault_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [TAG_W-1:0]   pc_tag_c;
  logic [OFS-1:0]     pc_ofs_c;
  logic [SLOT_W-1:0]  pc_slot_c;
  logic               misaligned_c;
  logic               tag_match_c;
  logic [31:0]        slot_data_c;
  logic               hit_c;
  logic               fill_en_c;
  logic               inval_en_c;

  assign pc_tag_c     = pc_i[31:OFS];
  assign pc_ofs_c     = pc_i[OFS-1:0];
  assign pc_slot_c    = SLOT_W'(pc_ofs_c >> IFU_ALIGN_W);
  assign misaligned_c = (pc_i[IFU_ALIGN_W-1:0] != '0);

  ifu_line #(
    .WORD_LEN (WORD_LEN),
    .TAG_W    (TAG_W),
    .SLOT_W   (SLOT_W)
  ) u_line (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .fill_en_i   (fill_en_c),
    .inval_en_i  (inval_en_c),
    .fill_tag_i  (mem_addr_q[31:OFS]),
    .fill_data_i (mem_data_i),
    .pc_tag_i    (pc_tag_c),
    .pc_slot_i   (pc_slot_c),
    .tag_match_c (tag_match_c),
    .slot_data_c (slot_data_c)
  );

  // Hit is live against the current PC so a PC change drops valid immediately.
  assign hit_c        = tag_match_c && !misaligned_c && !fault_q;
  assign inst_valid_o = hit_c;
  assign inst_o       = hit_c ? slot_data_c : '0;
  assign fault_o      = fault_q;
  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;

  // Fetch FSM next state: miss launches a request, ack fills, error/timeout faults.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fault_d    = fault_q;
    cnt_d      = cnt_q;
    fill_en_c  = 1'b0;
    inval_en_c = 1'b0;
    unique case (state_q)
      IFU_IDLE: begin
        if (misaligned_c) begin
          fault_d = 1'b1;
          state_d = IFU_FAULT;
        end else if (!hit_c) begin
          mem_req_d  = 1'b1;
          mem_addr_d = {pc_tag_c, {OFS{1'b0}}};
          cnt_d      = '0;
          state_d    = IFU_REQ;
        end
      end
      IFU_REQ: begin
        // Ack is checked first so an ack on the final count still fills.
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          cnt_d     = '0;
          if (mem_err_i) begin
            inval_en_c = 1'b1;
            fault_d    = 1'b1;
            state_d    = IFU_FAULT;
          end else begin
            fill_en_c = 1'b1;
            state_d   = IFU_IDLE;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          cnt_d     = '0;
          fault_d   = 1'b1;
          state_d   = IFU_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IFU_FAULT: state_d = IFU_FAULT;
      default:   state_d = IFU_IDLE;
    endcase
  end

  // FSM and registered bus/fault outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IFU_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu with a short timeout so the fault path is reachable.
module tb_ifu;
  import ifu_pkg::*;

  localparam int unsigned WORD_LEN = 64;
  localparam int unsigned TIMEOUT  = 4;

  logic                clk_i = 1'b0;
  logic                reset_i;
  logic [31:0]         pc_i;
  logic                inst_valid_o;
  logic [31:0]         inst_o;
  logic                fault_o;
  logic                mem_req_o;
  logic [31:0]         mem_addr_o;
  logic                mem_ack_i;
  logic [WORD_LEN-1:0] mem_data_i;
  logic                mem_err_i;

  int n_cmp = 0;
  int n_err = 0;

  ifu #(.WORD_LEN(WORD_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .pc_i         (pc_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .fault_o      (fault_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i),
    .mem_err_i    (mem_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one ack cycle, then return with ack removed and outputs settled.
  task automatic ack_cycle(input logic [63:0] d, input logic e);
    mem_ack_i  = 1'b1;
    mem_data_i = d;
    mem_err_i  = e;
    tick();
    mem_ack_i  = 1'b0;
    mem_err_i  = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_i    = 1'b1;
    pc_i       = 32'h0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    mem_err_i  = 1'b0;
    tick();
    tick();

    // Reset state
    check_eq("rst_valid", 64'(inst_valid_o), 64'h0);
    check_eq("rst_inst",  64'(inst_o),       64'h0);
    check_eq("rst_fault", 64'(fault_o),      64'h0);
    check_eq("rst_req",   64'(mem_req_o),    64'h0);
    check_eq("rst_addr",  64'(mem_addr_o),   64'h0);

    // Cold start: miss in cycle 0, request in cycle 1, ack in cycle 3
    reset_i = 1'b0;
    #1;
    check_eq("cold_req_c0", 64'(mem_req_o), 64'h0);
    tick();
    check_eq("cold_req_c1",  64'(mem_req_o),  64'h1);
    check_eq("cold_addr_c1", 64'(mem_addr_o), 64'h0);
    tick();
    check_eq("cold_valid_c2", 64'(inst_valid_o), 64'h0);
    tick();
    check_eq("cold_req_c3", 64'(mem_req_o), 64'h1);
    ack_cycle(64'h22222222_11111111, 1'b0);
    check_eq("cold_valid", 64'(inst_valid_o), 64'h1);
    check_eq("cold_inst",  64'(inst_o),       64'h11111111);
    check_eq("cold_req_off", 64'(mem_req_o),  64'h0);

    // Same line, slot 1: zero-cycle hit and no bus traffic
    pc_i = 32'h4;
    #1;
    check_eq("hit4_valid", 64'(inst_valid_o), 64'h1);
    check_eq("hit4_inst",  64'(inst_o),       64'h22222222);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hit4_noreq", 64'(mem_req_o), 64'h0);
    end

    // Line crossing with minimum latency (ack in first request cycle)
    pc_i = 32'h8;
    #1;
    check_eq("x8_valid_drop", 64'(inst_valid_o), 64'h0);
    tick();
    check_eq("x8_req",  64'(mem_req_o),  64'h1);
    check_eq("x8_addr", 64'(mem_addr_o), 64'h8);
    ack_cycle(64'h12345678_AAAA0001, 1'b0);
    check_eq("x8_valid", 64'(inst_valid_o), 64'h1);
    check_eq("x8_inst",  64'(inst_o),       64'hAAAA0001);
    pc_i = 32'hC;
    #1;
    check_eq("xC_inst", 64'(inst_o), 64'h12345678);

    // Stray ack/err while idle is ignored
    ack_cycle(64'hDEADBEEF_DEADBEEF, 1'b1);
    check_eq("stray_fault", 64'(fault_o),      64'h0);
    check_eq("stray_req",   64'(mem_req_o),    64'h0);
    check_eq("stray_inst",  64'(inst_o),       64'h12345678);

    // PC change while a request is outstanding
    pc_i = 32'h10;
    tick();
    check_eq("mid_req",  64'(mem_req_o),  64'h1);
    check_eq("mid_addr", 64'(mem_addr_o), 64'h10);
    pc_i = 32'h40;
    tick();
    check_eq("mid_addr_hold1", 64'(mem_addr_o), 64'h10);
    check_eq("mid_valid",      64'(inst_valid_o), 64'h0);
    tick();
    check_eq("mid_addr_hold2", 64'(mem_addr_o), 64'h10);
    ack_cycle(64'hBBBB0002_BBBB0001, 1'b0);
    check_eq("mid_idle_req",   64'(mem_req_o),    64'h0);
    check_eq("mid_idle_valid", 64'(inst_valid_o), 64'h0);
    tick();
    check_eq("mid_new_req",  64'(mem_req_o),  64'h1);
    check_eq("mid_new_addr", 64'(mem_addr_o), 64'h40);
    ack_cycle(64'hCCCC0002_CCCC0001, 1'b0);
    check_eq("mid_new_inst", 64'(inst_o), 64'hCCCC0001);

    // Ack on the final timeout count wins
    pc_i = 32'h80;
    tick();
    tick();
    tick();
    tick();
    check_eq("late_req_c4", 64'(mem_req_o), 64'h1);
    ack_cycle(64'hDDDD0002_DDDD0001, 1'b0);
    check_eq("late_fault", 64'(fault_o),      64'h0);
    check_eq("late_valid", 64'(inst_valid_o), 64'h1);
    check_eq("late_inst",  64'(inst_o),       64'hDDDD0001);

    // PC wrap 0xFFFFFFFC -> 0 is an ordinary miss
    pc_i = 32'hFFFF_FFFC;
    tick();
    check_eq("wrap_hi_addr", 64'(mem_addr_o), 64'hFFFF_FFF8);
    ack_cycle(64'hEEEE0002_EEEE0001, 1'b0);
    check_eq("wrap_hi_inst", 64'(inst_o), 64'hEEEE0002);
    pc_i = 32'h0;
    #1;
    check_eq("wrap_lo_drop", 64'(inst_valid_o), 64'h0);
    tick();
    check_eq("wrap_lo_req",  64'(mem_req_o),  64'h1);
    check_eq("wrap_lo_addr", 64'(mem_addr_o), 64'h0);
    ack_cycle(64'hFFFF0002_FFFF0001, 1'b0);
    check_eq("wrap_lo_inst", 64'(inst_o), 64'hFFFF0001);

    // Pure timeout: four request cycles, then fault
    pc_i = 32'h100;
    tick();
    tick();
    tick();
    tick();
    check_eq("to_req_c4",   64'(mem_req_o), 64'h1);
    check_eq("to_fault_c4", 64'(fault_o),   64'h0);
    tick();
    check_eq("to_req_drop", 64'(mem_req_o), 64'h0);
    check_eq("to_fault",    64'(fault_o),   64'h1);
    pc_i = 32'h0;
    #1;
    check_eq("to_valid_gated", 64'(inst_valid_o), 64'h0);
    tick();
    check_eq("to_req_stays", 64'(mem_req_o), 64'h0);

    // Misaligned PC faults without a request
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check_eq("rst2_fault", 64'(fault_o), 64'h0);
    pc_i = 32'h6;
    tick();
    check_eq("mis_fault", 64'(fault_o),   64'h1);
    check_eq("mis_req",   64'(mem_req_o), 64'h0);
    tick();
    check_eq("mis_req2",  64'(mem_req_o), 64'h0);

    // Reset during an outstanding request, then fresh refetch
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    pc_i = 32'h200;
    tick();
    check_eq("rr_req", 64'(mem_req_o), 64'h1);
    reset_i = 1'b1;
    tick();
    check_eq("rr_req_drop", 64'(mem_req_o),    64'h0);
    check_eq("rr_fault",    64'(fault_o),      64'h0);
    check_eq("rr_valid",    64'(inst_valid_o), 64'h0);
    reset_i = 1'b0;
    tick();
    check_eq("rr_refetch_req",  64'(mem_req_o),  64'h1);
    check_eq("rr_refetch_addr", 64'(mem_addr_o), 64'h200);
    ack_cycle(64'h55550002_55550001, 1'b0);
    check_eq("rr_inst", 64'(inst_o), 64'h55550001);

    // Bus error: sticky fault, line invalidated, no further requests
    pc_i = 32'h300;
    tick();
    check_eq("err_req", 64'(mem_req_o), 64'h1);
    ack_cycle(64'h66660002_66660001, 1'b1);
    check_eq("err_fault", 64'(fault_o),      64'h1);
    check_eq("err_valid", 64'(inst_valid_o), 64'h0);
    check_eq("err_req0",  64'(mem_req_o),    64'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("err_noreq", 64'(mem_req_o), 64'h0);
    end
    pc_i = 32'h200;
    #1;
    check_eq("err_valid_old", 64'(inst_valid_o), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifu.md
Name: ifu

Overview:
- Instruction fetch unit sitting directly upstream of the core control unit.
- Takes the control unit's program counter (`pc_i`) and returns the 32-bit instruction at that address, with a valid flag.
- Holds one prefetch line of WORD_LEN bits, filled over a simple req/ack memory port, so sequential instructions within a line hit without a bus access.
- Reports bus errors, timeouts and misaligned PCs as a sticky fault.

Parameters:
- WORD_LEN, 64, memory data width in bits; multiple of 32, ≥32; line holds WORD_LEN/32 instruction slots.
- TIMEOUT, 255, max cycles `mem_req_o` may stay high without `mem_ack_i` before faulting; ≥1.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- pc_i  in  32  program counter from control unit
- inst_valid_o  out  1  high when `inst_o` is the instruction at the current `pc_i`
- inst_o  out  32  instruction word
- fault_o  out  1  sticky fetch fault
- mem_req_o  out  1  memory read request
- mem_addr_o  out  32  line-aligned byte address
- mem_ack_i  in  1  memory completes request this cycle
- mem_data_i  in  WORD_LEN  read data, valid with `mem_ack_i`
- mem_err_i  in  1  bus error, valid with `mem_ack_i`

Behaviour:
- Line geometry:
  - LINE_BYTES = WORD_LEN/8; OFS = log2(LINE_BYTES).
  - tag = pc[31:OFS]; slot = pc[OFS-1:2].
  - Slot k = line_data[32k+31:32k] (little-endian).
- Hit:
  - hit = line_valid && line_tag == pc_i[31:OFS] && pc_i[1:0] == 0 && !fault.
  - `inst_valid_o` = hit, combinational from registered state and `pc_i`, so a PC change drops valid in the same cycle.
  - `inst_o` = selected slot when hit; 0 otherwise.
- Reset values:
  - `inst_valid_o`=0, `inst_o`=0, `fault_o`=0, `mem_req_o`=0, `mem_addr_o`=0.
  - line_valid=0, timeout counter=0, state IDLE.
- FSM:
  - IDLE:
    - If `pc_i[1:0]` != 0 → FAULT.
    - Else if !hit → REQ, registering `mem_addr_o` = {pc_i[31:OFS], OFS'b0} and `mem_req_o`=1 (request visible the cycle after the miss).
    - Else stay.
  - REQ:
    - `mem_req_o` and `mem_addr_o` held stable until the ack cycle; counter increments each cycle.
    - On posedge with `mem_ack_i`=1, `mem_err_i`=0: line_data ← `mem_data_i`, line_tag ← `mem_addr_o[31:OFS]`, line_valid ← 1, `mem_req_o` ← 0, counter ← 0 → IDLE.
    - On `mem_ack_i`=1, `mem_err_i`=1: `mem_req_o` ← 0, line_valid ← 0 → FAULT.
    - If counter reaches TIMEOUT without ack: `mem_req_o` ← 0 → FAULT.
  - FAULT:
    - `fault_o`=1 (registered); `inst_valid_o`=0; no further requests.
    - Exit only by reset.
- Latency:
  - Miss detected cycle 0, req high cycle 1; ack sampled at end of cycle n ≥ 1; `inst_valid_o` high cycle n+1.
  - Minimum miss-to-valid is 2 cycles.
  - Hit is 0 cycles.
- Boundary conditions:
  - `pc_i` changes while in REQ: request is not cancelled or re-addressed; fill completes with the original tag, then IDLE re-evaluates against the new `pc_i`.
  - Ack and timeout in the same cycle: ack wins.
  - `mem_ack_i` while `mem_req_o`=0: ignored.
  - PC wrap 0xFFFFFFFC→0: ordinary miss to line 0.
  - Reset mid-request: `mem_req_o` drops next cycle, line invalidated, fault cleared; the memory must tolerate an abandoned request.
  - `pc_i` stable on a hit line: no bus traffic.

Decomposition:
- Shared header `ifu.svh`:
  - `ifu_state_t` enum {IFU_IDLE, IFU_REQ, IFU_FAULT}.
  - `IFU_INST_BYTES` = 4.
- One natural sub-module: `ifu_line` (tag/data/valid storage plus slot mux and hit compare). The FSM and timeout stay in `ifu`.

Test Plan:
- Cold start: reset, pc_i=0, memory acks after 3 cycles with data 0x2222222211111111 → req cycle 1, `mem_addr_o`=0, valid with `inst_o`=0x11111111 cycle after ack; pc_i=4 → same-cycle valid, `inst_o`=0x22222222, no new req.
- Line crossing: pc_i 4→8 → valid drops same cycle, req with `mem_addr_o`=8; fill returns 0x...AAAA0001 → `inst_o`=0xAAAA0001.
- PC change mid-request: pc_i=0x10 req outstanding, pc_i→0x40 before ack → `mem_addr_o` stays 0x10 until ack, then new req for 0x40.
- Bus error: ack with `mem_err_i`=1 → `fault_o`=1 next cycle, `inst_valid_o`=0, `mem_req_o` never reasserts until reset.
- Timeout: TIMEOUT=4, no ack → `mem_req_o` drops and `fault_o`=1 after 4 request cycles; ack arriving with the final count → no fault, line filled.
- Misaligned pc_i=0x6 → FAULT, no request; reset during REQ → `mem_req_o`=0, `fault_o`=0 next cycle, fresh miss refetches.
